// File: rtl/hc595_rx_decoder.sv
// hc595_rx_decoder: receive side of a 74HC595 seven-segment display bus.
// Synchronizes ds/shcp/stcp/oe, reassembles 14-bit frames (sel[0..5] then
// seg[7..0]), validates them, decodes the segment pattern to a character
// code and keeps a six-position shadow of what the display is showing.
module hc595_rx_decoder #(
    parameter int SYNC_STAGES = 2  // legal values: 2 or 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        ds,
    input  logic        shcp,
    input  logic        stcp,
    input  logic        oe,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [5:0]  rx_sel,
    output logic [7:0]  rx_seg,
    output logic [2:0]  dig_idx,
    output logic [4:0]  dig_val,
    output logic        dig_dp,
    output logic [29:0] disp_val,
    output logic [5:0]  disp_dp,
    output logic        disp_on
);

    localparam logic [4:0] CODE_BLANK   = 5'd17;
    localparam logic [4:0] CODE_UNKNOWN = 5'd31;

    // Segment pattern (active-low, dp stripped) to character code.
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        logic [4:0] code;
        case (pat)
            7'h40: code = 5'd0;
            7'h79: code = 5'd1;
            7'h24: code = 5'd2;
            7'h30: code = 5'd3;
            7'h19: code = 5'd4;
            7'h12: code = 5'd5;
            7'h02: code = 5'd6;
            7'h78: code = 5'd7;
            7'h00: code = 5'd8;
            7'h10: code = 5'd9;
            7'h08: code = 5'd10;
            7'h03: code = 5'd11;
            7'h46: code = 5'd12;
            7'h21: code = 5'd13;
            7'h06: code = 5'd14;
            7'h0E: code = 5'd15;
            7'h3F: code = 5'd16;
            7'h7F: code = CODE_BLANK;
            default: code = CODE_UNKNOWN;
        endcase
        return code;
    endfunction

    // Index 0 is the first synchronizer flop. The clocks carry an extra
    // history flop for edge detection; ds and oe are only sampled, so they
    // stop at the last synchronizer stage.
    logic [SYNC_STAGES:0]   shcp_q;
    logic [SYNC_STAGES:0]   stcp_q;
    logic [SYNC_STAGES-1:0] ds_q;
    logic [SYNC_STAGES-1:0] oe_q;

    logic        shcp_rise;
    logic        stcp_rise;
    logic        ds_s;

    logic [13:0] sr_q, sr_d;
    logic [3:0]  cnt_q, cnt_d, cnt_sh;
    logic [5:0]  sel_w;
    logic [7:0]  seg_w;
    logic        sel_onehot;
    logic        frame_good;
    logic        frame_bad;
    logic [2:0]  dig_idx_d;
    logic [4:0]  dig_val_d;

    logic        frame_valid_q, frame_err_q;
    logic [5:0]  rx_sel_q;
    logic [7:0]  rx_seg_q;
    logic [2:0]  dig_idx_q;
    logic [4:0]  dig_val_q;
    logic        dig_dp_q;
    logic [29:0] disp_val_q;
    logic [5:0]  disp_dp_q;
    logic        disp_on_q;

    // Pin synchronizers plus history flops.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse
    // the synchronizer chain into a single stage.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            shcp_q <= '0;
            stcp_q <= '0;
            ds_q   <= '0;
            oe_q   <= '0;
        end else begin
            shcp_q <= {shcp_q[SYNC_STAGES-1:0], shcp};
            stcp_q <= {stcp_q[SYNC_STAGES-1:0], stcp};
            ds_q   <= {ds_q[SYNC_STAGES-2:0], ds};
            oe_q   <= {oe_q[SYNC_STAGES-2:0], oe};
        end
    end

    assign shcp_rise = shcp_q[SYNC_STAGES-1] & ~shcp_q[SYNC_STAGES];
    assign stcp_rise = stcp_q[SYNC_STAGES-1] & ~stcp_q[SYNC_STAGES];
    assign ds_s      = ds_q[SYNC_STAGES-1];

    // Shift/count next state and frame judgement. A simultaneous shcp and
    // stcp rise shifts first and judges the updated register and count.
    // NOTE: every signal assigned here gets a default at the top, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        sr_d       = sr_q;
        cnt_sh     = cnt_q;
        sel_w      = '0;
        dig_idx_d  = '0;
        if (shcp_rise) begin
            sr_d = {sr_q[12:0], ds_s};
            if (cnt_q != 4'd15) begin
                cnt_sh = cnt_q + 4'd1;
            end
        end
        cnt_d = stcp_rise ? 4'd0 : cnt_sh;

        // First received bit (sel[0]) ends up at the top of the register.
        for (int k = 0; k < 6; k++) begin
            sel_w[k] = sr_d[13-k];
        end
        seg_w = sr_d[7:0];

        sel_onehot = (sel_w != 6'd0) && ((sel_w & (sel_w - 6'd1)) == 6'd0);
        for (int i = 0; i < 6; i++) begin
            if (sel_w[i]) begin
                dig_idx_d = 3'(i);
            end
        end
        dig_val_d  = decode_seg(seg_w[6:0]);
        frame_good = stcp_rise && (cnt_sh == 4'd14) && sel_onehot;
        frame_bad  = stcp_rise && !frame_good;
    end

    // Frame assembly state.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    // Decoded outputs and the display shadow bank; only good frames update.
    // NOTE: the shadow bank is reset like any other register because the
    // display must read as blank (17) immediately after reset.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            rx_sel_q      <= 6'd0;
            rx_seg_q      <= 8'hFF;
            dig_idx_q     <= 3'd0;
            dig_val_q     <= CODE_BLANK;
            dig_dp_q      <= 1'b0;
            disp_val_q    <= {6{CODE_BLANK}};
            disp_dp_q     <= 6'd0;
        end else begin
            frame_valid_q <= frame_good;
            frame_err_q   <= frame_bad;
            if (frame_good) begin
                rx_sel_q                     <= sel_w;
                rx_seg_q                     <= seg_w;
                dig_idx_q                    <= dig_idx_d;
                dig_val_q                    <= dig_val_d;
                dig_dp_q                     <= ~seg_w[7];
                disp_val_q[5*dig_idx_d +: 5] <= dig_val_d;
                disp_dp_q[dig_idx_d]         <= ~seg_w[7];
            end
        end
    end

    // Display-enable report, registered to match the frame output latency.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            disp_on_q <= 1'b0;
        end else begin
            disp_on_q <= ~oe_q[SYNC_STAGES-1];
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign rx_sel      = rx_sel_q;
    assign rx_seg      = rx_seg_q;
    assign dig_idx     = dig_idx_q;
    assign dig_val     = dig_val_q;
    assign dig_dp      = dig_dp_q;
    assign disp_val    = disp_val_q;
    assign disp_dp     = disp_dp_q;
    assign disp_on     = disp_on_q;

endmodule

// File: tb/tb_hc595_rx_decoder.sv
// Self-checking bench for hc595_rx_decoder: directed display frames plus
// randomized frames checked against a frame-level reference model.
module tb_hc595_rx_decoder;

    localparam int S = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        ds, shcp, stcp, oe;
    logic        frame_valid, frame_err;
    logic [5:0]  rx_sel;
    logic [7:0]  rx_seg;
    logic [2:0]  dig_idx;
    logic [4:0]  dig_val;
    logic        dig_dp;
    logic [29:0] disp_val;
    logic [5:0]  disp_dp;
    logic        disp_on;

    int n_cmp = 0;
    int n_bad = 0;

    hc595_rx_decoder #(.SYNC_STAGES(S)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .ds         (ds),
        .shcp       (shcp),
        .stcp       (stcp),
        .oe         (oe),
        .frame_valid(frame_valid),
        .frame_err  (frame_err),
        .rx_sel     (rx_sel),
        .rx_seg     (rx_seg),
        .dig_idx    (dig_idx),
        .dig_val    (dig_val),
        .dig_dp     (dig_dp),
        .disp_val   (disp_val),
        .disp_dp    (disp_dp),
        .disp_on    (disp_on)
    );

    always #5 sys_clk = ~sys_clk;

    // ---------------- reference model ----------------
    logic [6:0] pat_tab [18] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                 7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                 7'h46, 7'h21, 7'h06, 7'h0E, 7'h3F, 7'h7F};

    logic [5:0] m_sel;
    logic [7:0] m_seg;
    logic [2:0] m_idx;
    logic [4:0] m_val;
    logic       m_dp;
    logic [4:0] m_bank_val [6];
    logic       m_bank_dp  [6];

    wire [58:0] obs_state = {rx_sel, rx_seg, dig_idx, dig_val, dig_dp, disp_val, disp_dp};

    function automatic logic [4:0] decode_ref(input logic [6:0] p);
        for (int i = 0; i < 18; i++) begin
            if (pat_tab[i] == p) return 5'(i);
        end
        return 5'd31;
    endfunction

    function automatic logic [58:0] exp_state();
        logic [29:0] bv;
        logic [5:0]  bd;
        for (int p = 0; p < 6; p++) begin
            bv[5*p +: 5] = m_bank_val[p];
            bd[p]        = m_bank_dp[p];
        end
        return {m_sel, m_seg, m_idx, m_val, m_dp, bv, bd};
    endfunction

    // Frame word: bit 13 is sent first (sel[0]), bit 0 last (seg[0]).
    function automatic logic [15:0] mk(input logic [5:0] sel, input logic [7:0] seg);
        logic [15:0] f;
        f = '0;
        for (int k = 0; k < 6; k++) f[13-k] = sel[k];
        f[7:0] = seg;
        return f;
    endfunction

    task automatic model_reset();
        m_sel = 6'd0; m_seg = 8'hFF; m_idx = 3'd0; m_val = 5'd17; m_dp = 1'b0;
        for (int p = 0; p < 6; p++) begin
            m_bank_val[p] = 5'd17;
            m_bank_dp[p]  = 1'b0;
        end
    endtask

    task automatic model_frame(input logic [15:0] data, input int n, output bit good);
        logic [5:0] sel;
        for (int k = 0; k < 6; k++) sel[k] = data[13-k];
        good = (n == 14) && ($countones(sel) == 1);
        if (good) begin
            m_sel = sel;
            m_seg = data[7:0];
            for (int k = 0; k < 6; k++) if (sel[k]) m_idx = 3'(k);
            m_val = decode_ref(data[6:0]);
            m_dp  = ~data[7];
            m_bank_val[m_idx] = m_val;
            m_bank_dp[m_idx]  = m_dp;
        end
    endtask

    // ---------------- pin drivers (all changes on negedge) ----------------
    task automatic shift_bit(input logic b, input bit with_stcp);
        shcp = 1'b0;
        ds   = b;
        repeat ($urandom_range(2, 3)) @(negedge sys_clk);
        shcp = 1'b1;
        if (with_stcp) begin
            stcp = 1'b1;
        end else begin
            repeat ($urandom_range(2, 3)) @(negedge sys_clk);
        end
    endtask

    // Raises stcp (unless already raised together with the last shcp) and
    // watches a bounded window. k=1 is the first negedge after edge N.
    task automatic end_frame(input bit simul, output logic [19:0] pobs);
        int vk, ek, nv, ne, both;
        vk = 0; ek = 0; nv = 0; ne = 0; both = 0;
        if (!simul) begin
            shcp = 1'b0;
            repeat (2) @(negedge sys_clk);
            stcp = 1'b1;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge sys_clk);
            if (frame_valid === 1'b1 && vk == 0) vk = k;
            if (frame_err === 1'b1 && ek == 0) ek = k;
            if (frame_valid === 1'b1) nv++;
            if (frame_err === 1'b1) ne++;
            if (frame_valid === 1'b1 && frame_err === 1'b1) both++;
            if (k == 2) begin
                stcp = 1'b0;
                shcp = 1'b0;
            end
        end
        pobs = {4'(vk), 4'(ek), 4'(nv), 4'(ne), 4'(both)};
    endtask

    task automatic run_frame(input logic [15:0] data, input int n, input bit simul,
                             output logic [19:0] pobs, output logic [19:0] pexp);
        bit good;
        for (int i = n - 1; i >= 0; i--) shift_bit(data[i], simul && (i == 0));
        end_frame(simul && (n > 0), pobs);
        model_frame(data, n, good);
        pexp = good ? {4'(S + 1), 4'd0, 4'd1, 4'd0, 4'd0}
                    : {4'd0, 4'(S + 1), 4'd0, 4'd1, 4'd0};
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        sys_rst = 1'b1; ds = 1'b0; shcp = 1'b0; stcp = 1'b0; oe = 1'b1;
        model_reset();
        repeat (3) @(negedge sys_clk);
        n_cmp++;
        if (obs_state !== exp_state()) begin
            n_bad++; $display("FAIL reset_state: got %h expected %h", obs_state, exp_state());
        end
        n_cmp++;
        if ({frame_valid, frame_err, disp_on} !== 3'b000) begin
            n_bad++; $display("FAIL reset_pulses: got %b expected 000", {frame_valid, frame_err, disp_on});
        end
        sys_rst = 1'b0;
        repeat (4) @(negedge sys_clk);
        n_cmp++;
        if ({obs_state, frame_valid, frame_err, disp_on} !== {exp_state(), 3'b000}) begin
            n_bad++; $display("FAIL post_reset_idle: got %h expected %h", {obs_state, frame_valid, frame_err, disp_on}, {exp_state(), 3'b000});
        end
    endtask

    task automatic test_single_digit();
        logic [19:0] po, pe;
        run_frame(mk(6'b000100, 8'hA4), 14, 1'b0, po, pe);
        n_cmp++;
        if (po !== pe) begin n_bad++; $display("FAIL digit2_pulse: got %h expected %h", po, pe); end
        n_cmp++;
        if (obs_state !== exp_state()) begin n_bad++; $display("FAIL digit2_state: got %h expected %h", obs_state, exp_state()); end
        n_cmp++;
        if ({dig_idx, dig_val, dig_dp, disp_val} !== {3'd2, 5'd2, 1'b0, 5'd17, 5'd17, 5'd17, 5'd2, 5'd17, 5'd17}) begin
            n_bad++; $display("FAIL digit2_bank: got %h", {dig_idx, dig_val, dig_dp, disp_val});
        end
        run_frame(mk(6'b100000, 8'h40), 14, 1'b0, po, pe);
        n_cmp++;
        if (po !== pe) begin n_bad++; $display("FAIL digit0dp_pulse: got %h expected %h", po, pe); end
        n_cmp++;
        if ({dig_idx, dig_val, dig_dp, disp_dp} !== {3'd5, 5'd0, 1'b1, 6'b100000}) begin
            n_bad++; $display("FAIL digit0dp_fields: got %h expected %h", {dig_idx, dig_val, dig_dp, disp_dp}, {3'd5, 5'd0, 1'b1, 6'b100000});
        end
    endtask

    task automatic test_scan();
        logic [19:0] po, pe;
        logic [7:0] segs [6] = '{8'h8E, 8'h88, 8'hB0, 8'h24, 8'hF9, 8'hBF};  // positions 0..5
        for (int p = 5; p >= 0; p--) begin
            run_frame(mk(6'(1 << p), segs[p]), 14, 1'b0, po, pe);
            n_cmp++;
            if (po !== pe) begin n_bad++; $display("FAIL scan_pulse_%0d: got %h expected %h", p, po, pe); end
        end
        n_cmp++;
        if ({disp_val, disp_dp} !== {5'd16, 5'd1, 5'd2, 5'd3, 5'd10, 5'd15, 6'b001000}) begin
            n_bad++; $display("FAIL scan_bank: got %h expected %h", {disp_val, disp_dp}, {5'd16, 5'd1, 5'd2, 5'd3, 5'd10, 5'd15, 6'b001000});
        end
        n_cmp++;
        if (obs_state !== exp_state()) begin n_bad++; $display("FAIL scan_state: got %h expected %h", obs_state, exp_state()); end
    endtask

    task automatic test_errors();
        logic [19:0] po, pe;
        logic [15:0] d [3];
        int          n [3];
        d[0] = mk(6'b000001, 8'h79); n[0] = 13;
        d[1] = mk(6'b000001, 8'h79) | 16'h4000; n[1] = 15;
        d[2] = mk(6'b000011, 8'h79); n[2] = 14;
        for (int i = 0; i < 3; i++) begin
            run_frame(d[i], n[i], 1'b0, po, pe);
            n_cmp++;
            if (po !== pe) begin n_bad++; $display("FAIL err_pulse_%0d: got %h expected %h", i, po, pe); end
            n_cmp++;
            if (obs_state !== exp_state()) begin n_bad++; $display("FAIL err_state_%0d: got %h expected %h", i, obs_state, exp_state()); end
        end
    endtask

    task automatic test_unknown();
        logic [19:0] po, pe;
        run_frame(mk(6'(1 << $urandom_range(0, 5)), 8'hFF), 14, 1'b0, po, pe);
        n_cmp++;
        if ({po, dig_val} !== {pe, 5'd17}) begin n_bad++; $display("FAIL blank_code: got %h expected %h", {po, dig_val}, {pe, 5'd17}); end
        run_frame(mk(6'(1 << $urandom_range(0, 5)), 8'h55), 14, 1'b0, po, pe);
        n_cmp++;
        if ({po, dig_val, dig_dp} !== {pe, 5'd31, 1'b1}) begin n_bad++; $display("FAIL unknown_code: got %h expected %h", {po, dig_val, dig_dp}, {pe, 5'd31, 1'b1}); end
        n_cmp++;
        if (obs_state !== exp_state()) begin n_bad++; $display("FAIL unknown_state: got %h expected %h", obs_state, exp_state()); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] po, pe;
        logic [15:0] d;
        logic [5:0]  sel;
        logic [7:0]  seg;
        int          n, r;
        bit          simul;
        for (int t = 0; t < 30; t++) begin
            r   = $urandom_range(0, 9);
            n   = 14;
            sel = 6'(1 << $urandom_range(0, 5));
            seg = ($urandom_range(0, 1) == 1) ? {1'($urandom_range(0, 1)), pat_tab[$urandom_range(0, 17)]}
                                               : 8'($urandom);
            if (r == 0) n = 13;
            if (r == 1) n = $urandom_range(15, 17);
            if (r == 2) begin
                sel = 6'($urandom);
                while ($countones(sel) == 1) sel = 6'($urandom);
            end
            d     = mk(sel, seg) | (16'($urandom) & 16'hC000);
            simul = ($urandom_range(0, 1) == 1);
            run_frame(d, n, simul, po, pe);
            n_cmp++;
            if (po !== pe) begin n_bad++; $display("FAIL rand_pulse_%0d: got %h expected %h", t, po, pe); end
            n_cmp++;
            if (obs_state !== exp_state()) begin n_bad++; $display("FAIL rand_state_%0d: got %h expected %h", t, obs_state, exp_state()); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [19:0] po, pe;
        for (int i = 0; i < 7; i++) shift_bit(1'($urandom), 1'b0);
        sys_rst = 1'b1;
        shcp    = 1'b0;
        model_reset();
        repeat (2) @(negedge sys_clk);
        n_cmp++;
        if (obs_state !== exp_state()) begin n_bad++; $display("FAIL midreset_state: got %h expected %h", obs_state, exp_state()); end
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        run_frame(16'd0, 0, 1'b0, po, pe);
        n_cmp++;
        if (po !== pe) begin n_bad++; $display("FAIL midreset_err: got %h expected %h", po, pe); end
        run_frame(mk(6'b010000, 8'h99), 14, 1'b0, po, pe);
        n_cmp++;
        if ({po, obs_state} !== {pe, exp_state()}) begin n_bad++; $display("FAIL midreset_clean: got %h expected %h", {po, obs_state}, {pe, exp_state()}); end
    endtask

    task automatic test_oe();
        logic [3:0] seen;
        oe = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge sys_clk);
            seen[k-1] = disp_on;
        end
        n_cmp++;
        if (seen !== 4'b1100) begin n_bad++; $display("FAIL oe_low_latency: got %b expected 1100", seen); end
        oe = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge sys_clk);
            seen[k-1] = disp_on;
        end
        n_cmp++;
        if (seen !== 4'b0011) begin n_bad++; $display("FAIL oe_high_latency: got %b expected 0011", seen); end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_scan();
        test_errors();
        test_unknown();
        test_back_to_back();
        test_reset_midframe();
        test_oe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
